// File: rtl/divisor_ula.sv
// Multi-cycle 8-bit unsigned restoring divider that borrows the datapath ALU's
// subtract mode and borrow flag to resolve one quotient bit per clock.
module divisor_ula (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inicio,
  input  logic [7:0] dividendo,
  input  logic [7:0] divisor,
  output logic       ocupado,
  output logic       pronto,
  output logic [7:0] quociente,
  output logic [7:0] resto,
  output logic       div_zero,
  output logic       controle_ula,
  output logic [7:0] ula_a,
  output logic [7:0] ula_b,
  input  logic [7:0] saida_ula,
  input  logic       zero,
  input  logic       negativo
);

  typedef enum logic [1:0] {OCIOSO, CALC, FIM} state_t;

  state_t     state;
  logic [7:0] d_reg;
  logic [7:0] r_reg;
  logic [7:0] v_reg;
  logic [2:0] cont;

  logic [7:0] shifted;
  logic [7:0] r_next;
  logic [7:0] d_next;
  logic       qbit;
  logic       unused_zero;

  assign unused_zero = zero;

  // Partial remainder stays below 128 before each shift, so dropping r_reg[7] loses nothing.
  assign shifted = {r_reg[6:0], d_reg[7]};
  assign qbit    = ~negativo;
  assign r_next  = negativo ? shifted : saida_ula;
  assign d_next  = {d_reg[6:0], qbit};

  always_comb begin
    controle_ula = 1'b0;
    ula_a        = 8'd0;
    ula_b        = 8'd0;
    if (state == CALC) begin
      controle_ula = 1'b1;
      ula_a        = shifted;
      ula_b        = v_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OCIOSO;
      ocupado   <= 1'b0;
      pronto    <= 1'b0;
      div_zero  <= 1'b0;
      quociente <= 8'd0;
      resto     <= 8'd0;
      d_reg     <= 8'd0;
      r_reg     <= 8'd0;
      v_reg     <= 8'd0;
      cont      <= 3'd0;
    end else begin
      pronto <= 1'b0;
      case (state)
        OCIOSO: begin
          if (inicio) begin
            ocupado <= 1'b1;
            if (divisor == 8'd0) begin
              quociente <= 8'hFF;
              resto     <= dividendo;
              div_zero  <= 1'b1;
              pronto    <= 1'b1;
              state     <= FIM;
            end else begin
              d_reg <= dividendo;
              v_reg <= divisor;
              r_reg <= 8'd0;
              cont  <= 3'd0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          d_reg <= d_next;
          r_reg <= r_next;
          cont  <= cont + 3'd1;
          if (cont == 3'd7) begin
            quociente <= d_next;
            resto     <= r_next;
            div_zero  <= 1'b0;
            pronto    <= 1'b1;
            state     <= FIM;
          end
        end
        FIM: begin
          ocupado <= 1'b0;
          state   <= OCIOSO;
        end
        default: begin
          ocupado <= 1'b0;
          state   <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_ula.sv
// Directed and random checks of divisor_ula with a behavioural ALU on its ula_* ports.
module tb_divisor_ula;

  logic       clk;
  logic       rst_n;
  logic       inicio;
  logic [7:0] dividendo;
  logic [7:0] divisor;
  logic       ocupado;
  logic       pronto;
  logic [7:0] quociente;
  logic [7:0] resto;
  logic       div_zero;
  logic       controle_ula;
  logic [7:0] ula_a;
  logic [7:0] ula_b;
  logic [7:0] saida_ula;
  logic       zero;
  logic       negativo;

  int n_checks = 0;
  int n_fail   = 0;
  int drive_bad = 0;

  divisor_ula dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .dividendo(dividendo), .divisor(divisor),
    .ocupado(ocupado), .pronto(pronto), .quociente(quociente), .resto(resto),
    .div_zero(div_zero), .controle_ula(controle_ula), .ula_a(ula_a), .ula_b(ula_b),
    .saida_ula(saida_ula), .zero(zero), .negativo(negativo)
  );

  // Behavioural stand-in for the single-cycle ALU: add/subtract with borrow flag.
  assign saida_ula = controle_ula ? (ula_a - ula_b) : (ula_a + ula_b);
  assign zero      = (saida_ula == 8'd0);
  assign negativo  = controle_ula & (ula_a < ula_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (!ocupado && (controle_ula || ula_a != 8'd0 || ula_b != 8'd0)) drive_bad++;

  // Entered just after a rising edge; returns right after the cycle following pronto.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b, output int lat,
                        output logic [7:0] q, output logic [7:0] r, output logic dz,
                        output logic busy0, output logic [1:0] tail);
    inicio = 1'b1; dividendo = a; divisor = b;
    @(posedge clk); #1;
    inicio = 1'b0; dividendo = 8'($urandom); divisor = 8'($urandom);
    busy0 = ocupado;
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      if (pronto) begin lat = k; break; end
      @(posedge clk); #1;
    end
    q = quociente; r = resto; dz = div_zero;
    @(posedge clk); #1;
    tail = {pronto, ocupado};
    $display("div %0d/%0d -> q=%0d r=%0d dz=%0b lat=%0d", a, b, q, r, dz, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inicio = 1'b0; dividendo = 8'd0; divisor = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ocupado, pronto, div_zero, quociente, resto, controle_ula, ula_a, ula_b} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b pr=%b dz=%b a=%0d b=%0d, required all 0",
               quociente, resto, ocupado, pronto, div_zero, ula_a, ula_b);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({ocupado, pronto} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b pronto=%b, required 0 0", ocupado, pronto);
    end
  endtask

  task automatic test_basic();
    int lat; logic [7:0] q, r; logic dz, busy0; logic [1:0] tail;
    do_div(8'd200, 8'd7, lat, q, r, dz, busy0, tail);
    n_checks++;
    if ({q, r, dz} !== {8'd28, 8'd4, 1'b0}) begin
      n_fail++; $display("FAIL basic_200_7: got q=%0d r=%0d dz=%b, required 28 4 0", q, r, dz);
    end
    n_checks++;
    if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d, required 8", lat); end
    n_checks++;
    if (busy0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, required 1", busy0); end
    n_checks++;
    if (tail !== 2'b00) begin
      n_fail++; $display("FAIL basic_pronto_width: got pronto,busy=%b, required 00", tail);
    end
  endtask

  task automatic test_edges();
    logic [7:0] va [5] = '{8'd255, 8'd10, 8'd200, 8'd255, 8'd0};
    logic [7:0] vb [5] = '{8'd1,   8'd20, 8'd200, 8'd255, 8'd9};
    logic [7:0] eq [5] = '{8'd255, 8'd0,  8'd1,   8'd1,   8'd0};
    logic [7:0] er [5] = '{8'd0,   8'd10, 8'd0,   8'd0,   8'd0};
    int lat; logic [7:0] q, r; logic dz, busy0; logic [1:0] tail;
    for (int i = 0; i < 5; i++) begin
      do_div(va[i], vb[i], lat, q, r, dz, busy0, tail);
      n_checks++;
      if ({q, r, dz} !== {eq[i], er[i], 1'b0} || lat !== 8) begin
        n_fail++;
        $display("FAIL edge_%0d_%0d: got q=%0d r=%0d dz=%b lat=%0d, required q=%0d r=%0d dz=0 lat=8",
                 va[i], vb[i], q, r, dz, lat, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat; logic [7:0] q, r; logic dz, busy0; logic [1:0] tail;
    do_div(8'd37, 8'd0, lat, q, r, dz, busy0, tail);
    n_checks++;
    if ({q, r, dz} !== {8'hFF, 8'd37, 1'b1}) begin
      n_fail++; $display("FAIL divzero_result: got q=%0d r=%0d dz=%b, required 255 37 1", q, r, dz);
    end
    n_checks++;
    if (lat !== 0 || busy0 !== 1'b1 || tail !== 2'b00) begin
      n_fail++;
      $display("FAIL divzero_timing: got lat=%0d busy=%b tail=%b, required 0 1 00", lat, busy0, tail);
    end
    do_div(8'd9, 8'd3, lat, q, r, dz, busy0, tail);
    n_checks++;
    if ({q, r, dz} !== {8'd3, 8'd0, 1'b0} || lat !== 8) begin
      n_fail++;
      $display("FAIL divzero_clear: got q=%0d r=%0d dz=%b lat=%0d, required 3 0 0 8", q, r, dz, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] q, r; logic dz, busy0; logic [1:0] tail;
    inicio = 1'b1; dividendo = 8'd100; divisor = 8'd9;
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    inicio = 1'b1; dividendo = 8'd50; divisor = 8'd5;
    @(posedge clk); #1;
    inicio = 1'b0;
    lat = -1;
    for (int k = 3; k < 30; k++) begin
      if (pronto) begin lat = k; break; end
      @(posedge clk); #1;
    end
    $display("div 100/9 (ignored 50/5) -> q=%0d r=%0d dz=%0b lat=%0d", quociente, resto, div_zero, lat);
    n_checks++;
    if ({quociente, resto, div_zero} !== {8'd11, 8'd1, 1'b0} || lat !== 8) begin
      n_fail++;
      $display("FAIL ignore_inicio: got q=%0d r=%0d dz=%b lat=%0d, required 11 1 0 8",
               quociente, resto, div_zero, lat);
    end
    @(posedge clk); #1;
    do_div(8'd45, 8'd6, lat, q, r, dz, busy0, tail);
    n_checks++;
    if ({q, r, dz} !== {8'd7, 8'd3, 1'b0} || lat !== 8 || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back: got q=%0d r=%0d dz=%b lat=%0d busy=%b, required 7 3 0 8 1",
               q, r, dz, lat, busy0);
    end
  endtask

  task automatic test_mid_reset();
    int lat; logic [7:0] q, r; logic dz, busy0; logic [1:0] tail;
    logic seen;
    inicio = 1'b1; dividendo = 8'd200; divisor = 8'd7;
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ocupado, pronto, div_zero, quociente, resto, controle_ula, ula_a, ula_b} !== 36'd0) begin
      n_fail++;
      $display("FAIL midreset_async: got q=%0d r=%0d busy=%b pr=%b a=%0d b=%0d ctl=%b, required all 0",
               quociente, resto, ocupado, pronto, ula_a, ula_b, controle_ula);
    end
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; seen |= pronto; end
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; seen |= pronto | ocupado; end
    $display("reset during 200/7 -> pronto/busy seen=%b", seen);
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL midreset_no_pronto: got %b, required 0", seen);
    end
    do_div(8'd81, 8'd9, lat, q, r, dz, busy0, tail);
    n_checks++;
    if ({q, r, dz} !== {8'd9, 8'd0, 1'b0} || lat !== 8) begin
      n_fail++;
      $display("FAIL midreset_after: got q=%0d r=%0d dz=%b lat=%0d, required 9 0 0 8", q, r, dz, lat);
    end
  endtask

  task automatic test_random();
    int lat; logic [7:0] q, r; logic dz, busy0; logic [1:0] tail;
    logic [7:0] a, b, eq, er;
    int elat;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (b == 8'd0) begin eq = 8'hFF; er = a; elat = 0; end
      else begin eq = a / b; er = a % b; elat = 8; end
      do_div(a, b, lat, q, r, dz, busy0, tail);
      n_checks++;
      if ({q, r, dz} !== {eq, er, (b == 8'd0)} || lat !== elat) begin
        n_fail++;
        $display("FAIL random_%0d_%0d: got q=%0d r=%0d dz=%b lat=%0d, required q=%0d r=%0d lat=%0d",
                 a, b, q, r, dz, lat, eq, er, elat);
      end
    end
    n_checks++;
    if (drive_bad !== 0) begin
      n_fail++; $display("FAIL idle_alu_drive: got %0d nonzero idle cycles, required 0", drive_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
